counter_arbiter: RTL and testbench
==================================

# counter_arbiter

Shared-counter access controller: arbitrates up to NREQ requesters onto a single WIDTH-bit counter register with round-robin fairness, executing READ, INC, LOAD and RUN operations, one per cycle. It sits beside the counter-style submodules used in the alias/hierarchy lint tests and supplies one owner for the counter state that several consumers observe or modify. Every operation returns the pre-operation counter value on a registered response port.

## Interface
- NREQ, 4: number of requesters (2..16)
- WIDTH, 32: counter width in bits
- IDW, $clog2(NREQ): requester index width (localparam)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester grant/accept, at most one bit high
- req_op  input  2*NREQ  per-requester op, slice i = req_op[2i+1:2i]; 00 READ, 01 INC, 10 LOAD, 11 RUN
- req_data  input  WIDTH*NREQ  per-requester operand, slice i = req_data[WIDTH*i +: WIDTH]
- rsp_valid  output  1  response strobe, one cycle per accepted op
- rsp_id  output  IDW  index of requester that owns the response
- rsp_data  output  WIDTH  counter value before the op executed
- count  output  WIDTH  current counter value (register)
- running  output  1  free-run mode flag

## Operation
- Reset values: count=0, running=0, rsp_valid=0, rsp_id=0, rsp_data=0, round-robin pointer=0, req_ready=0.
- Arbitration: combinational. Grant goes to the first requester with req_valid=1, searching upward from the pointer and wrapping. req_ready[g]=1 only for the granted index. req_ready depends on req_valid; requesters must not make req_valid depend on req_ready.
- Accept = req_valid[g] & req_ready[g]. On accept, the pointer becomes (g+1) mod NREQ. With no accept, the pointer holds.
- Ops, applied at the accepting edge:
  - READ: count unchanged.
  - INC: count+1.
  - LOAD: count=operand.
  - RUN: running=operand[0]; count follows the free-run rule for that cycle.
- Free-run: when running=1 and the accepted op is not INC or LOAD, count increments by 1 each cycle. The old running value governs the RUN cycle.
- Precedence: LOAD > INC > free-run. INC while running adds only 1, not 2.
- Arithmetic is modulo 2^WIDTH unless COUNTER_ARB_SAT_EN is defined.
- Response: registered. rsp_valid=1 in the cycle after accept, with rsp_id=g and rsp_data=count sampled before the update. There is no response backpressure. rsp_id and rsp_data hold their last values when rsp_valid=0.
- Reset asserted mid-operation: the in-flight response is dropped, and all state returns to reset values asynchronously.

## Timing
- Accept in cycle T. count updates at edge T→T+1. rsp_valid is high during T+1.
- Throughput is one op per cycle, with back-to-back grants allowed to different requesters or to the same one.
- A single requester held valid with no competitors is granted every cycle.
- No combinational path from req_* to rsp_*, count or running.

## Configuration
- COUNTER_ARB_SAT_EN defined: INC and free-run saturate at all-ones. Once count is all-ones it stays there until LOAD or reset. LOAD is unaffected.
- Undefined: INC and free-run wrap from all-ones to 0.

## Structure
- Shared package counter_arb_pkg holds:
  - enum cnt_op_e {OP_READ, OP_INC, OP_LOAD, OP_RUN}, 2-bit.
  - localparams for op encodings.
- One sub-module, rr_pick: a parameterised round-robin picker.
  - Inputs: valid vector and pointer.
  - Outputs: one-hot grant, grant index, any-valid.
- FSM: a single `running` state bit (IDLE/RUN) plus a response-pending flag. No other control states.

## Test plan
- Reset with all req_valid high (NREQ=4): req_ready=0 and count=0 during reset. In the first cycle after release, requester 0 is granted.
- All four requesters hold READ continuously: grants go 0,1,2,3,0,… and rsp_id follows one cycle later.
- Requester 2 LOADs 0x0000_00FE, then INC on the next cycle: rsp_data=old value then 0xFE, and count=0xFF after the INC.
- RUN data=1 from count=10, idle for 5 cycles, then INC while running: count sequence 10,11,…,15,16, and the INC cycle adds only 1.
- LOAD 0xFFFF_FFFF then INC: count=0 without the macro, 0xFFFF_FFFF with COUNTER_ARB_SAT_EN; free-run shows the same behaviour.
- Assert rst_n low in the cycle after an accept: rsp_valid never rises, and count, running and the pointer return to 0.

Source files
------------

// File: rtl/counter_arb_pkg.sv
// Shared definitions for the counter arbiter: op encodings and run-state enum.
// Optional feature macro: COUNTER_ARB_SAT_EN (saturating INC / free-run).
package counter_arb_pkg;

  localparam logic [1:0] OPC_READ = 2'b00;
  localparam logic [1:0] OPC_INC  = 2'b01;
  localparam logic [1:0] OPC_LOAD = 2'b10;
  localparam logic [1:0] OPC_RUN  = 2'b11;

  typedef enum logic [1:0] {
    OP_READ = OPC_READ,
    OP_INC  = OPC_INC,
    OP_LOAD = OPC_LOAD,
    OP_RUN  = OPC_RUN
  } cnt_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first valid requester at or above ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Rotating priority search starting at the pointer.
  always_comb begin
    int unsigned j;
    logic        found;
    j     = '0;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr_i) + k) % N;
      if (!found && valid_i[IW'(j)]) begin
        found            = 1'b1;
        gnt_o[IW'(j)]    = 1'b1;
        idx_o            = IW'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/counter_arbiter.sv
// Shared-counter access controller: round-robin arbitration of READ/INC/LOAD/RUN
// onto one counter, with a registered pre-op response.
// Optional feature macro: COUNTER_ARB_SAT_EN (INC and free-run saturate at all-ones).
module counter_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [2*NREQ-1:0]        req_op,
  input  logic [WIDTH*NREQ-1:0]    req_data,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [WIDTH-1:0]         count,
  output logic                     running
);

  import counter_arb_pkg::*;

  localparam int unsigned IDW = $clog2(NREQ);

  run_state_e       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [NREQ-1:0]  gnt_c;
  logic [IDW-1:0]   gidx_c;
  logic             any_c;
  cnt_op_e          op_c;
  logic [WIDTH-1:0] opnd_c;
  logic [WIDTH-1:0] bumped_c;

  rr_pick #(
    .N  (NREQ),
    .IW (IDW)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt_c),
    .idx_o   (gidx_c),
    .any_o   (any_c)
  );

  // Grant is suppressed while reset is held.
  assign req_ready = gnt_c & {NREQ{rst_n}};

  // Select the granted requester's op and operand.
  always_comb begin
    op_c   = OP_READ;
    opnd_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gidx_c == IDW'(i)) begin
        op_c   = cnt_op_e'(req_op[2*i +: 2]);
        opnd_c = req_data[WIDTH*i +: WIDTH];
      end
    end
  end

  // Counter increment, wrapping or saturating depending on build.
`ifdef COUNTER_ARB_SAT_EN
  assign bumped_c = (&count_q) ? count_q : count_q + WIDTH'(1);
`else
  assign bumped_c = count_q + WIDTH'(1);
`endif

  // Next-state: LOAD beats INC beats free-run; RUN takes effect next cycle.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    ptr_d       = ptr_q;
    rsp_valid_d = any_c;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (state_q == ST_RUN) begin
      count_d = bumped_c;
    end
    if (any_c) begin
      ptr_d      = (gidx_c == IDW'(NREQ-1)) ? '0 : gidx_c + IDW'(1);
      rsp_id_d   = gidx_c;
      rsp_data_d = count_q;
      case (op_c)
        OP_INC:  count_d = bumped_c;
        OP_LOAD: count_d = opnd_c;
        OP_RUN:  state_d = opnd_c[0] ? ST_RUN : ST_IDLE;
        default: ;
      endcase
    end
  end

  // State registers; reset drops any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign count     = count_q;
  assign running   = (state_q == ST_RUN);

endmodule

// File: tb/tb_counter_arbiter.sv
// Self-checking bench for counter_arbiter (NREQ=4, WIDTH=32) against a
// behavioural model of the shared counter and round-robin grant order.
module tb_counter_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 32;
  localparam logic [1:0] RD = 2'b00, INC = 2'b01, LD = 2'b10, RUN = 2'b11;
`ifdef COUNTER_ARB_SAT_EN
  localparam logic [31:0] AFTER_MAX = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] AFTER_MAX = 32'h0000_0000;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [7:0]   req_op;
  logic [127:0] req_data;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;
  logic [31:0]  count;
  logic         running;

  counter_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .count     (count),
    .running   (running)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [31:0] m_count, m_rdata;
  logic        m_running, m_rv;
  int          m_ptr, m_rid;

  function automatic int exp_grant(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(input logic [3:0] v, input int ptr);
    logic [3:0] r;
    int g;
    r = 4'b0;
    g = exp_grant(v, ptr);
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] plus1(input logic [31:0] c);
`ifdef COUNTER_ARB_SAT_EN
    if (c == 32'hFFFF_FFFF) return c;
`endif
    return c + 32'd1;
  endfunction

  task automatic model_reset();
    m_count = '0; m_rdata = '0; m_running = 1'b0; m_rv = 1'b0; m_ptr = 0; m_rid = 0;
  endtask

  task automatic model_apply();
    int g;
    logic [1:0]  op;
    logic [31:0] d, nc;
    logic        nr;
    g  = exp_grant(req_valid, m_ptr);
    nc = m_running ? plus1(m_count) : m_count;
    nr = m_running;
    if (g >= 0) begin
      op      = req_op[2*g +: 2];
      d       = req_data[32*g +: 32];
      m_rv    = 1'b1;
      m_rid   = g;
      m_rdata = m_count;
      m_ptr   = (g + 1) % 4;
      if (op == INC) nc = plus1(m_count);
      if (op == LD)  nc = d;
      if (op == RUN) nr = d[0];
    end else begin
      m_rv = 1'b0;
    end
    m_count   = nc;
    m_running = nr;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] d);
    req_op[2*i +: 2]    = op;
    req_data[32*i +: 32] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    model_apply();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; req_op = '0; req_data = '0;
    model_reset();
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    n_checks++; if (count !== 32'd0) begin n_fail++; $display("FAIL reset_count got=%h exp=0", count); end
    n_checks++; if (rsp_valid !== 1'b0 || running !== 1'b0) begin n_fail++; $display("FAIL reset_flags rsp_valid=%b running=%b exp=0", rsp_valid, running); end
    n_checks++; if (rsp_id !== 2'd0 || rsp_data !== 32'd0) begin n_fail++; $display("FAIL reset_rsp id=%0d data=%h exp=0", rsp_id, rsp_data); end
    rst_n = 1'b1;
    #2;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL first_grant got=%b exp=0001", req_ready); end
    tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL first_rsp valid=%b id=%0d exp=1/0", rsp_valid, rsp_id); end
  endtask

  task automatic test_round_robin();
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) set_req(i, RD, 32'hA0 + 32'(i));
    for (int n = 0; n < 8; n++) begin
      #2;
      n_checks++; if (req_ready !== exp_ready(req_valid, m_ptr)) begin n_fail++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", n, req_ready, exp_ready(req_valid, m_ptr)); end
      n_checks++; if (req_ready !== (4'b0001 << ((n + 1) % 4))) begin n_fail++; $display("FAIL rr_order cyc=%0d got=%b exp=%b", n, req_ready, 4'b0001 << ((n + 1) % 4)); end
      tick();
      n_checks++; if (rsp_valid !== 1'b1 || 32'(rsp_id) !== 32'(m_rid) || rsp_data !== m_rdata) begin n_fail++; $display("FAIL rr_rsp cyc=%0d valid=%b id=%0d data=%h exp id=%0d data=%h", n, rsp_valid, rsp_id, rsp_data, m_rid, m_rdata); end
    end
  endtask

  task automatic test_load_inc();
    logic [31:0] prev;
    prev = m_count;
    req_valid = 4'b0100;
    set_req(2, LD, 32'h0000_00FE);
    #2;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL li_ready got=%b exp=0100", req_ready); end
    tick();
    n_checks++; if (rsp_data !== prev || count !== 32'hFE) begin n_fail++; $display("FAIL li_load rsp=%h count=%h exp rsp=%h count=fe", rsp_data, count, prev); end
    set_req(2, INC, 32'h0);
    tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'hFE || count !== 32'hFF) begin n_fail++; $display("FAIL li_inc valid=%b id=%0d rsp=%h count=%h exp 1/2/fe/ff", rsp_valid, rsp_id, rsp_data, count); end
    req_valid = 4'b0000;
    tick();
    n_checks++; if (rsp_valid !== 1'b0 || rsp_id !== 2'd2 || rsp_data !== 32'hFE || count !== 32'hFF) begin n_fail++; $display("FAIL li_hold valid=%b id=%0d rsp=%h count=%h exp 0/2/fe/ff", rsp_valid, rsp_id, rsp_data, count); end
  endtask

  task automatic test_run();
    req_valid = 4'b0010;
    set_req(1, LD, 32'd10);
    tick();
    set_req(1, RUN, 32'd1);
    tick();
    n_checks++; if (count !== 32'd10 || running !== 1'b1) begin n_fail++; $display("FAIL run_start count=%0d running=%b exp 10/1", count, running); end
    req_valid = 4'b0000;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_checks++; if (count !== 32'(10 + k) || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL run_free k=%0d count=%0d rsp_valid=%b exp %0d/0", k, count, rsp_valid, 10 + k); end
    end
    req_valid = 4'b0010;
    set_req(1, INC, 32'd0);
    tick();
    n_checks++; if (count !== 32'd16 || rsp_data !== 32'd15) begin n_fail++; $display("FAIL run_inc count=%0d rsp=%0d exp 16/15", count, rsp_data); end
    set_req(1, RUN, 32'd0);
    tick();
    n_checks++; if (count !== 32'd17 || running !== 1'b0) begin n_fail++; $display("FAIL run_stop count=%0d running=%b exp 17/0", count, running); end
    req_valid = 4'b0000;
    tick();
    n_checks++; if (count !== 32'd17 || count !== m_count) begin n_fail++; $display("FAIL run_idle count=%0d exp 17", count); end
  endtask

  task automatic test_wrap();
    req_valid = 4'b1000;
    set_req(3, LD, 32'hFFFF_FFFF);
    tick();
    set_req(3, INC, 32'h0);
    tick();
    n_checks++; if (count !== AFTER_MAX) begin n_fail++; $display("FAIL wrap_inc count=%h exp %h", count, AFTER_MAX); end
    set_req(3, LD, 32'hFFFF_FFFF);
    tick();
    set_req(3, RUN, 32'h1);
    tick();
    n_checks++; if (count !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_runcyc count=%h exp ffffffff", count); end
    req_valid = 4'b0000;
    tick();
    n_checks++; if (count !== AFTER_MAX) begin n_fail++; $display("FAIL wrap_free count=%h exp %h", count, AFTER_MAX); end
    req_valid = 4'b1000;
    set_req(3, RUN, 32'h0);
    tick();
    n_checks++; if (count !== plus1(AFTER_MAX) || running !== 1'b0) begin n_fail++; $display("FAIL wrap_stop count=%h running=%b exp %h/0", count, running, plus1(AFTER_MAX)); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      req_valid = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0)
          set_req(i, 2'($urandom), 32'hFFFF_FFFF - 32'($urandom_range(0, 2)));
        else
          set_req(i, 2'($urandom), $urandom);
      end
      #2;
      n_checks++; if (req_ready !== exp_ready(req_valid, m_ptr)) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", n, req_ready, exp_ready(req_valid, m_ptr)); end
      tick();
      n_checks++; if (count !== m_count || running !== m_running) begin n_fail++; $display("FAIL rnd_state cyc=%0d count=%h running=%b exp %h/%b", n, count, running, m_count, m_running); end
      n_checks++; if (rsp_valid !== m_rv || 32'(rsp_id) !== 32'(m_rid) || rsp_data !== m_rdata) begin n_fail++; $display("FAIL rnd_rsp cyc=%0d valid=%b id=%0d data=%h exp %b/%0d/%h", n, rsp_valid, rsp_id, rsp_data, m_rv, m_rid, m_rdata); end
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0100;
    set_req(2, RD, 32'h0);
    tick();
    req_valid = 4'b0010;
    set_req(1, RUN, 32'h1);
    tick();
    req_valid = 4'b0001;
    set_req(0, INC, 32'h0);
    #2;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_ready got=%b exp=0001", req_ready); end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0 || count !== 32'd0 || running !== 1'b0 || req_ready !== 4'b0) begin n_fail++; $display("FAIL mid_async valid=%b count=%h running=%b ready=%b exp all 0", rsp_valid, count, running, req_ready); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b0 || count !== 32'd0) begin n_fail++; $display("FAIL mid_held k=%0d valid=%b count=%h exp 0/0", k, rsp_valid, count); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) set_req(i, RD, 32'h0);
    #2;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr got=%b exp=0001", req_ready); end
    tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'd0 || count !== 32'd0) begin n_fail++; $display("FAIL mid_after valid=%b id=%0d data=%h count=%h exp 1/0/0/0", rsp_valid, rsp_id, rsp_data, count); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_load_inc();
    test_run();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
